// File: rtl/mem_access_pkg.sv
// Shared encodings for the byte-wide BRAM access path:
// request sizes, sequencer states and word geometry.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Size code 3 is treated as a full word.
  function automatic logic [2:0] size_bytes(
    input logic [1:0] sz
  );
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Zero/sign extension of an assembled little-endian load
// of 1, 2 or 4 lanes to the full word width.
module load_extend
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [WORD_BYTES*DATA_WIDTH-1:0] raw,
  input  logic [2:0]                       nbytes,
  input  logic                             sgn,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] result
);

  localparam int DW = DATA_WIDTH;

  logic fill;

  always_comb begin
    fill   = 1'b0;
    result = raw;
    unique case (1'b1)
      (nbytes == 3'd1): begin
        fill   = sgn & raw[DW-1];
        result = {{(3*DW){fill}}, raw[DW-1:0]};
      end
      (nbytes == 3'd2): begin
        fill   = sgn & raw[2*DW-1];
        result = {{(2*DW){fill}}, raw[2*DW-1:0]};
      end
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/bram_byte_sequencer.sv
// Load/store initiator for a byte-wide single-port BRAM:
// one byte per cycle, little-endian, read latency hidden.
module bram_byte_sequencer
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [1:0]                       req_size,
  input  logic                             req_signed,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [WORD_BYTES*DATA_WIDTH-1:0] req_wdata,
  output logic                             resp_valid,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] resp_rdata,
  output logic                             bram_we,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [DATA_WIDTH-1:0]            bram_din,
  input  logic [DATA_WIDTH-1:0]            bram_dout
);

  localparam int DW = DATA_WIDTH;
  localparam int WW = WORD_BYTES * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;

  state_t          state;
  logic [2:0]      n_q;
  logic            sgn_q;
  logic [WW-1:0]   wdata_q;
  logic [2:0]      iss;
  logic [1:0]      cap;
  logic [WW-1:0]   rbuf;
  logic [WW-1:0]   raw;
  logic [WW-1:0]   ext;
  logic            last_cap;

  // The final byte is taken straight from the BRAM
  // so the response leaves on the same edge it arrives.
  always_comb begin
    raw = rbuf;
    raw[cap*DW +: DW] = bram_dout;
  end

  assign last_cap = ({1'b0, cap} == (n_q - 3'd1));

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ext (
    .raw   (raw),
    .nbytes(n_q),
    .sgn   (sgn_q),
    .result(ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      n_q        <= 3'd0;
      sgn_q      <= 1'b0;
      wdata_q    <= '0;
      iss        <= 3'd0;
      cap        <= 2'd0;
      rbuf       <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            n_q       <= size_bytes(req_size);
            sgn_q     <= req_signed;
            wdata_q   <= req_wdata;
            bram_addr <= req_addr;
            bram_we   <= req_we;
            bram_din  <= req_we ? req_wdata[DW-1:0]
                                : '0;
            iss       <= 3'd1;
            cap       <= 2'd0;
            rbuf      <= '0;
            req_ready <= 1'b0;
            state     <= req_we ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          iss <= iss + 3'd1;
          if (iss < n_q)
            bram_addr <= bram_addr + A_ONE;
          if (iss >= 3'd2) begin
            rbuf[cap*DW +: DW] <= bram_dout;
            cap <= cap + 2'd1;
            if (last_cap) begin
              resp_rdata <= ext;
              resp_valid <= 1'b1;
              req_ready  <= 1'b1;
              state      <= ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          if (iss < n_q) begin
            bram_addr <= bram_addr + A_ONE;
            bram_din  <= wdata_q[iss[1:0]*DW +: DW];
            iss       <= iss + 3'd1;
          end else begin
            bram_we    <= 1'b0;
            bram_din   <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_byte_sequencer.sv
// Bench for bram_byte_sequencer: BRAM model plus a
// byte-array reference memory for expected results.
module tb_bram_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        bram_we;
  logic [15:0] bram_addr;
  logic [7:0]  bram_din;
  logic [7:0]  bram_dout;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        clr;
  logic [15:0] wq_a [$];
  logic [7:0]  wq_d [$];

  always #5 clk = ~clk;

  bram_byte_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    end else begin
      if (bram_we) begin
        mem[bram_addr] <= bram_din;
        wq_a.push_back(bram_addr);
        wq_d.push_back(bram_din);
      end
    end
    bram_dout <= mem[bram_addr];
  end

  function automatic int nb(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(
    input logic [15:0] a, input logic [1:0] sz,
    input logic sg);
    int n;
    logic [31:0] v;
    n = nb(sz);
    v = 32'h0;
    for (int k = 0; k < n; k++)
      v[8*k +: 8] = ref_mem[a + 16'(k)];
    if (sg && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic model_store(input logic [15:0] a,
    input logic [1:0] sz, input logic [31:0] wd);
    for (int k = 0; k < nb(sz); k++)
      ref_mem[a + 16'(k)] = wd[8*k +: 8];
  endtask

  // Runs one request; reports latency from acceptance,
  // response data, ready-low while busy, single pulse.
  task automatic do_req(input logic we,
    input logic [1:0] sz, input logic sg,
    input logic [15:0] a, input logic [31:0] wd,
    output int lat, output logic [31:0] rd,
    output bit busy_ok, output bit one_pulse);
    bit rdy;
    bit acc;
    req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin acc = 1; break; end
    end
    req_valid = 1'b0;
    lat = 0; rd = 32'hX; busy_ok = acc; one_pulse = 0;
    if (acc) begin
      for (int i = 1; i <= 20; i++) begin
        if (req_ready) busy_ok = 0;
        @(posedge clk); #1;
        if (resp_valid) begin
          lat = i; rd = resp_rdata; break;
        end
      end
      @(posedge clk); #1;
      one_pulse = !resp_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (bram_we !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async we=%b rv=%b want 0 0",
               bram_we, resp_valid);
    end
    repeat (3) @(posedge clk);
    #1; clr = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_resp got %b/%h want 0/0",
               resp_valid, resp_rdata);
    end
    checks++;
    if (bram_we !== 1'b0 || bram_addr !== 16'h0 ||
        bram_din !== 8'h0) begin
      errors++;
      $display("FAIL reset_bram got %b/%h/%h want 0/0/0",
               bram_we, bram_addr, bram_din);
    end
  endtask

  task automatic test_word_store();
    int lat; logic [31:0] rd; bit bz, op;
    logic [31:0] wd;
    wd = 32'hDEADBEEF;
    wq_a.delete(); wq_d.delete();
    do_req(1'b1, 2'd2, 1'b0, 16'h0100, wd, lat, rd, bz, op);
    model_store(16'h0100, 2'd2, wd);
    checks++;
    if (lat != 4 || rd !== 32'h0 || !bz || !op) begin
      errors++;
      $display("FAIL store_resp lat=%0d rd=%h bz=%b op=%b want 4 0 1 1",
               lat, rd, bz, op);
    end
    checks++;
    if (wq_a.size() != 4) begin
      errors++;
      $display("FAIL store_we_cycles got %0d want 4",
               wq_a.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wq_a[k] !== 16'h0100 + 16'(k) ||
            wq_d[k] !== wd[8*k +: 8]) begin
          errors++;
          $display("FAIL store_byte%0d got %h=%h want %h=%h",
                   k, wq_a[k], wq_d[k],
                   16'h0100 + 16'(k), wd[8*k +: 8]);
        end
      end
    end
    checks++;
    if (bram_we !== 1'b0) begin
      errors++;
      $display("FAIL store_we_idle got %b want 0", bram_we);
    end
  endtask

  task automatic test_word_load();
    int lat; logic [31:0] rd; bit bz, op;
    do_req(1'b0, 2'd2, 1'b0, 16'h0100, 32'h0,
           lat, rd, bz, op);
    checks++;
    if (lat != 5 || !bz || !op) begin
      errors++;
      $display("FAIL load_timing lat=%0d bz=%b op=%b want 5 1 1",
               lat, bz, op);
    end
    checks++;
    if (rd !== 32'hDEADBEEF ||
        rd !== model_load(16'h0100, 2'd2, 1'b0)) begin
      errors++;
      $display("FAIL load_word got %h want deadbeef", rd);
    end
  endtask

  task automatic test_narrow_loads();
    logic [15:0] ta [4] = '{16'h0103, 16'h0103,
                            16'h0102, 16'h0101};
    logic [1:0]  ts [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        tg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] te [4] = '{32'hFFFFFFDE, 32'h000000DE,
                            32'hFFFFDEAD, 32'h0000ADBE};
    int lat; logic [31:0] rd; bit bz, op;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, ts[i], tg[i], ta[i], 32'h0,
             lat, rd, bz, op);
      checks++;
      if (rd !== te[i] || lat != nb(ts[i]) + 1 ||
          rd !== model_load(ta[i], ts[i], tg[i])) begin
        errors++;
        $display("FAIL narrow%0d got %h lat=%0d want %h lat=%0d",
                 i, rd, lat, te[i], nb(ts[i]) + 1);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ea [4] = '{16'hFFFE, 16'hFFFF,
                            16'h0000, 16'h0001};
    logic [7:0]  ed [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    int lat; logic [31:0] rd; bit bz, op;
    wq_a.delete(); wq_d.delete();
    do_req(1'b1, 2'd2, 1'b0, 16'hFFFE, 32'h11223344,
           lat, rd, bz, op);
    model_store(16'hFFFE, 2'd2, 32'h11223344);
    checks++;
    if (wq_a.size() != 4) begin
      errors++;
      $display("FAIL wrap_we_cycles got %0d want 4",
               wq_a.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wq_a[k] !== ea[k] || wq_d[k] !== ed[k]) begin
          errors++;
          $display("FAIL wrap_byte%0d got %h=%h want %h=%h",
                   k, wq_a[k], wq_d[k], ea[k], ed[k]);
        end
      end
    end
    do_req(1'b0, 2'd2, 1'b0, 16'hFFFE, 32'h0,
           lat, rd, bz, op);
    checks++;
    if (rd !== 32'h11223344 || lat != 5) begin
      errors++;
      $display("FAIL wrap_load got %h lat=%0d want 11223344 5",
               rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; bit bz, op;
    bit rdy, acc, seen;
    req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 16'h0200; req_wdata = 32'hAABBCCDD;
    req_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin acc = 1; break; end
    end
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (!acc || bram_we !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre acc=%b we=%b want 1 1",
               acc, bram_we);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bram_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_we got %b want 0", bram_we);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) seen = 1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_resp seen=%b rdy=%b want 0 1",
               seen, req_ready);
    end
    ref_mem[16'h0200] = 8'hDD;
    ref_mem[16'h0201] = 8'hCC;
    do_req(1'b0, 2'd2, 1'b0, 16'h0200, 32'h0,
           lat, rd, bz, op);
    checks++;
    if (rd !== 32'h0000CCDD ||
        rd !== model_load(16'h0200, 2'd2, 1'b0)) begin
      errors++;
      $display("FAIL rstmid_load got %h want 0000ccdd", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic        bw [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  bs [3] = '{2'd2, 2'd2, 2'd1};
    logic        bg [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] ba [3];
    logic [31:0] exp_q [$];
    logic [15:0] base;
    logic [31:0] wd;
    bit rdy, rv, acc;
    logic [31:0] rdv;
    int nresp;
    base = 16'(32'h0800 + $urandom_range(0, 255));
    wd = $urandom();
    ba[0] = base; ba[1] = base; ba[2] = base + 16'd1;
    nresp = 0;
    for (int i = 0; i < 3; i++) begin
      req_we = bw[i]; req_size = bs[i];
      req_signed = bg[i]; req_addr = ba[i];
      req_wdata = bw[i] ? wd : 32'h0;
      req_valid = 1'b1;
      acc = 0;
      for (int c = 0; c < 50; c++) begin
        rdy = req_ready; rv = resp_valid;
        rdv = resp_rdata;
        @(posedge clk); #1;
        if (rv) begin
          checks++;
          if (nresp >= exp_q.size() ||
              rdv !== exp_q[nresp]) begin
            errors++;
            $display("FAIL b2b_resp%0d got %h", nresp, rdv);
          end
          nresp++;
        end
        if (rdy) begin acc = 1; break; end
      end
      checks++;
      if (!acc || (i > 0 && !rv)) begin
        errors++;
        $display("FAIL b2b_accept%0d acc=%b on_resp=%b want 1 1",
                 i, acc, rv);
      end
      if (bw[i]) begin
        model_store(ba[i], bs[i], wd);
        exp_q.push_back(32'h0);
      end else begin
        exp_q.push_back(model_load(ba[i], bs[i], bg[i]));
      end
    end
    req_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        checks++;
        if (nresp >= exp_q.size() ||
            resp_rdata !== exp_q[nresp]) begin
          errors++;
          $display("FAIL b2b_resp%0d got %h", nresp,
                   resp_rdata);
        end
        nresp++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nresp != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", nresp);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; bit bz, op;
    logic we, sg; logic [1:0] sz;
    logic [15:0] a; logic [31:0] wd, ex;
    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0)
           ? 16'(32'hFFFC + $urandom_range(0, 7))
           : 16'(32'h0400 + $urandom_range(0, 31));
      wd = $urandom();
      ex = we ? 32'h0 : model_load(a, sz, sg);
      do_req(we, sz, sg, a, wd, lat, rd, bz, op);
      if (we) model_store(a, sz, wd);
      checks++;
      if (rd !== ex || lat != nb(sz) + (we ? 0 : 1) ||
          !bz || !op) begin
        errors++;
        $display("FAIL rand%0d we=%b sz=%0d a=%h got %h lat=%0d want %h lat=%0d",
                 i, we, sz, a, rd, lat, ex,
                 nb(sz) + (we ? 0 : 1));
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 16'h0;
    req_wdata = 32'h0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_word_store();
    test_word_load();
    test_narrow_loads();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_byte_sequencer.md
Name: bram_byte_sequencer

Overview:
- Initiator side of the single-port byte-wide synchronous BRAM interface.
- Accepts byte, half-word or word load/store requests from the CPU load/store stage over a valid/ready handshake.
- Sequences one BRAM byte access per cycle, little-endian, and hides the 1-cycle BRAM read latency.
- Returns assembled, optionally sign-extended, load data or a store acknowledge as a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 16, BRAM byte-address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, BRAM lane width; word width is 4*DATA_WIDTH (32 at default).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; handshake on the clk edge where valid&ready.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=treated as word.
- req_signed  in  1  sign-extend byte/half loads; ignored for stores and words.
- req_addr  in  ADDR_WIDTH  start byte address; any alignment allowed.
- req_wdata  in  4*DATA_WIDTH  store data; the low N bytes are used.
- resp_valid  out  1  one-cycle pulse: load data valid, or store complete.
- resp_rdata  out  4*DATA_WIDTH  load result; 0 for store acks.
- bram_we  out  1  to BRAM we.
- bram_addr  out  ADDR_WIDTH  to BRAM addr.
- bram_din  out  DATA_WIDTH  to BRAM din.
- bram_dout  in  DATA_WIDTH  from BRAM dout, valid one edge after the address is sampled.

Behaviour:
- **Reset values:** req_ready=1 after reset release; resp_valid=0; resp_rdata=0; bram_we=0; bram_addr=0; bram_din=0; state=IDLE; counters=0.
- **Sizing:** N = 1/2/4 bytes for size 0/1/2; size 3 gives N=4. Byte k uses address req_addr+k (wrapping) and lane bits [8k+7:8k].
- **FSM states:** IDLE, READ, WRITE. All BRAM-side outputs are registered.
- **Handshake (edge E0):** latch all request fields and load byte 0 onto bram_addr/bram_din/bram_we. Go to READ if req_we=0, else WRITE.
- **READ:**
  - Issue counter advances bram_addr one byte per edge, E0..E(N-1). A separate capture counter stores bram_dout at E2..E(N+1).
  - At E(N+1): resp_rdata is loaded with the assembled value, zero- or sign-extended per req_signed and N; resp_valid<=1; state->IDLE.
  - Load latency is N+1 edges from acceptance (word = 5).
- **WRITE:**
  - bram_we=1 for N consecutive cycles (bytes registered E0..E(N-1)).
  - At E(N): bram_we<=0, bram_din<=0, resp_valid<=1, resp_rdata<=0, state->IDLE.
  - Store latency is N edges.
- **Read-after-write visibility:** the earliest next request is accepted at E(N+1), so a following load observes all written bytes.
- **Between requests:** resp_valid is high exactly one cycle and has no backpressure. req_ready is high in that same cycle, so back-to-back acceptance is allowed.
- **Busy:** req_valid while busy is ignored. No queuing; the requester must hold req_valid.
- **Idle outputs:** bram_addr holds its last value; bram_we=0.
- **Reset mid-operation:** immediately returns to IDLE with bram_we=0 and no response issued. Bytes already written stay in memory; the remaining bytes are not written.
- **Wrap-around:** address 2^ADDR_WIDTH-1 is followed by 0 within one request.

Decomposition:
- Shared package/header mem_access_pkg: size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), FSM state encodings, and a WORD_BYTES=4 constant.
- One sub-module is natural: load_extend, combinational. It takes the assembled bytes, N and req_signed, and produces the 32-bit zero/sign-extended result.

Test Plan:
1. Word store 0xDEADBEEF @0x0100 -> bram_we high exactly 4 cycles; addr 0x0100..0x0103; din EF,BE,AD,DE; resp_valid pulse 4 edges after accept with rdata=0.
2. Word load @0x0100 -> resp_valid exactly 5 edges after accept; resp_rdata=0xDEADBEEF; req_ready low for the intermediate cycles.
3. Narrow loads from the data in test 1:
   - byte @0x0103 signed -> 0xFFFFFFDE
   - byte @0x0103 unsigned -> 0x000000DE
   - half @0x0102 signed -> 0xFFFFDEAD
   - half @0x0101 unsigned -> 0x0000ADBE (unaligned)
4. Wrap: word store 0x11223344 @0xFFFE -> writes FFFE=44, FFFF=33, 0000=22, 0001=11; word load @0xFFFE returns 0x11223344.
5. Assert rst after the second byte of a word store of 0xAABBCCDD @0x0200 (pre-filled 0) -> bram_we drops asynchronously; no resp_valid; then word load @0x0200 returns 0x0000CCDD.
6. Back-to-back with req_valid held high: store then load are accepted on the resp_valid cycle of the previous request. A new req_valid asserted mid-operation is not accepted until IDLE, and no request is lost or duplicated.
